// File: rtl/gpio_pkg.sv
// Shared constants and types for the GPIO interrupt controller slice.
package gpio_pkg;

    localparam int unsigned GPIO_PORT_NUM_DEF = 32;
    localparam int unsigned DEBOUNCE_W_DEF    = 8;
    localparam int unsigned SYNC_DEPTH        = 2;

    typedef enum logic {
        IRQ_EDGE  = 1'b0,
        IRQ_LEVEL = 1'b1
    } irq_mode_e;

endpackage

// File: rtl/gpio_debounce.sv
// Per-pin input conditioning: synchronizer, optional debounce counter and
// filtered-level register. filt_next is the value filt takes on the next edge.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_W = DEBOUNCE_W_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  raw,
    input  logic                  db_en,
    input  logic [DEBOUNCE_W-1:0] db_limit,
    output logic                  filt,
    output logic                  filt_next
);

    logic [SYNC_DEPTH-1:0] sync_r;
    logic                  sync_q;
    logic [DEBOUNCE_W-1:0] cnt;
    logic [DEBOUNCE_W-1:0] cnt_next;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-2:0], raw};
        end
    end

    assign sync_q = sync_r[SYNC_DEPTH-1];

    // >= rather than == so a limit lowered below the running count still
    // releases on the next compare; the increment only happens below the
    // limit, so the counter can never wrap.
    always_comb begin
        filt_next = filt;
        cnt_next  = '0;
        if (!db_en) begin
            filt_next = sync_q;
        end else if (sync_q != filt) begin
            if (cnt >= db_limit) begin
                filt_next = sync_q;
            end else begin
                cnt_next = cnt + DEBOUNCE_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            filt <= filt_next;
        end
    end

endmodule

// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: per-pin conditioning, edge detect, W1C pending
// flags and a registered combined irq. GPIO_IRQ_LEVEL_EN adds level-high mode.
module gpio_irq_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned GPIO_PORT_NUM = GPIO_PORT_NUM_DEF,
    parameter int unsigned DEBOUNCE_W    = DEBOUNCE_W_DEF
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [GPIO_PORT_NUM-1:0] gpio_input,
    input  logic [GPIO_PORT_NUM-1:0] db_en,
    input  logic [DEBOUNCE_W-1:0]    db_limit,
    input  logic [GPIO_PORT_NUM-1:0] irq_rise_en,
    input  logic [GPIO_PORT_NUM-1:0] irq_fall_en,
    input  logic [GPIO_PORT_NUM-1:0] irq_mask,
    input  logic [GPIO_PORT_NUM-1:0] irq_clr,
`ifdef GPIO_IRQ_LEVEL_EN
    input  logic [GPIO_PORT_NUM-1:0] irq_level_sel,
`endif
    output logic [GPIO_PORT_NUM-1:0] gpio_filtered,
    output logic [GPIO_PORT_NUM-1:0] irq_pending,
    output logic                     irq_out
);

    logic [GPIO_PORT_NUM-1:0] filt_next;
    logic [GPIO_PORT_NUM-1:0] rise;
    logic [GPIO_PORT_NUM-1:0] fall;
    logic [GPIO_PORT_NUM-1:0] pend_set;

    for (genvar i = 0; i < GPIO_PORT_NUM; i++) begin : g_pin
        gpio_debounce #(
            .DEBOUNCE_W(DEBOUNCE_W)
        ) u_debounce (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .raw       (gpio_input[i]),
            .db_en     (db_en[i]),
            .db_limit  (db_limit),
            .filt      (gpio_filtered[i]),
            .filt_next (filt_next[i])
        );
    end

    assign rise = ~gpio_filtered &  filt_next;
    assign fall =  gpio_filtered & ~filt_next;

    always_comb begin
        pend_set = (rise & irq_rise_en) | (fall & irq_fall_en);
`ifdef GPIO_IRQ_LEVEL_EN
        for (int unsigned i = 0; i < GPIO_PORT_NUM; i++) begin
            if (irq_mode_e'(irq_level_sel[i]) == IRQ_LEVEL) begin
                pend_set[i] = filt_next[i];
            end
        end
`endif
    end

    // Set terms are OR'd after the clear so a coincident event wins.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            irq_pending <= '0;
            irq_out     <= 1'b0;
        end else begin
            irq_pending <= (irq_pending & ~irq_clr) | pend_set;
            irq_out     <= |(irq_pending & irq_mask);
        end
    end

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl: vector table, directed corner cases
// and randomized traffic against a behavioural model.
module tb_gpio_irq_ctrl;

    localparam int N = 32;
    localparam int W = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic [N-1:0]  gpio_input, db_en, irq_rise_en, irq_fall_en, irq_mask, irq_clr;
    logic [W-1:0]  db_limit;
`ifdef GPIO_IRQ_LEVEL_EN
    logic [N-1:0]  irq_level_sel;
`endif
    logic [N-1:0]  gpio_filtered, irq_pending;
    logic          irq_out;

    gpio_irq_ctrl #(
        .GPIO_PORT_NUM(N),
        .DEBOUNCE_W   (W)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .gpio_input    (gpio_input),
        .db_en         (db_en),
        .db_limit      (db_limit),
        .irq_rise_en   (irq_rise_en),
        .irq_fall_en   (irq_fall_en),
        .irq_mask      (irq_mask),
        .irq_clr       (irq_clr),
`ifdef GPIO_IRQ_LEVEL_EN
        .irq_level_sel (irq_level_sel),
`endif
        .gpio_filtered (gpio_filtered),
        .irq_pending   (irq_pending),
        .irq_out       (irq_out)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: sync = raw delayed two edges; filt follows sync once
    // it has disagreed for (limit+1) consecutive edges (limit 0 when bypassed).
    logic [N-1:0] m_s1, m_s2, m_filt, m_pend;
    logic         m_irq;
    int           m_run [N];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_filt = '0; m_pend = '0; m_irq = 1'b0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] fn;
        int lim;
        fn = m_filt;
        m_irq = |(m_pend & irq_mask);
        for (int i = 0; i < N; i++) begin
            lim = db_en[i] ? int'(db_limit) : 0;
            if (m_s2[i] != m_filt[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] > lim) begin
                    fn[i] = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            if (irq_clr[i]) m_pend[i] = 1'b0;
            if (!m_filt[i] && fn[i] && irq_rise_en[i]) m_pend[i] = 1'b1;
            if (m_filt[i] && !fn[i] && irq_fall_en[i]) m_pend[i] = 1'b1;
`ifdef GPIO_IRQ_LEVEL_EN
            if (irq_level_sel[i]) m_pend[i] = (m_pend[i] & ~irq_clr[i]) | fn[i];
`endif
        end
        m_filt = fn;
        m_s2 = m_s1;
        m_s1 = gpio_input;
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
    endtask

    task automatic inputs_idle();
        gpio_input = '0; db_en = '0; db_limit = '0; irq_rise_en = '0;
        irq_fall_en = '0; irq_mask = '0; irq_clr = '0;
`ifdef GPIO_IRQ_LEVEL_EN
        irq_level_sel = '0;
`endif
    endtask

    task automatic apply_reset();
        sys_rst_n = 1'b0;
        inputs_idle();
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0] raw, rise, fall, mask, clr, efilt, epend;
        logic         eirq;
    } vec_t;

    vec_t tbl [17];
    logic [N-1:0] seen;

    initial begin
        sys_rst_n = 1'b0;
        inputs_idle();
        model_reset();

        // Bypass pin 3 rise / W1C, then pin 0 fall-only with masking.
        tbl[0]  = '{32'h8, 32'h8, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{32'h8, 32'h8, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[2]  = '{32'h8, 32'h8, 32'h0, 32'h8, 32'h0, 32'h8, 32'h8, 1'b0};
        tbl[3]  = '{32'h8, 32'h8, 32'h0, 32'h8, 32'h0, 32'h8, 32'h8, 1'b1};
        tbl[4]  = '{32'h8, 32'h8, 32'h0, 32'h8, 32'h8, 32'h8, 32'h0, 1'b1};
        tbl[5]  = '{32'h8, 32'h8, 32'h0, 32'h8, 32'h0, 32'h8, 32'h0, 1'b0};
        tbl[6]  = '{32'h0, 32'h8, 32'h0, 32'h8, 32'h0, 32'h8, 32'h0, 1'b0};
        tbl[7]  = '{32'h0, 32'h8, 32'h0, 32'h8, 32'h0, 32'h8, 32'h0, 1'b0};
        tbl[8]  = '{32'h0, 32'h8, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[9]  = '{32'h1, 32'h8, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[10] = '{32'h1, 32'h8, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0};
        tbl[11] = '{32'h0, 32'h8, 32'h1, 32'h1, 32'h0, 32'h1, 32'h0, 1'b0};
        tbl[12] = '{32'h0, 32'h8, 32'h1, 32'h1, 32'h0, 32'h1, 32'h0, 1'b0};
        tbl[13] = '{32'h0, 32'h8, 32'h1, 32'h1, 32'h0, 32'h0, 32'h1, 1'b0};
        tbl[14] = '{32'h0, 32'h8, 32'h1, 32'h1, 32'h0, 32'h0, 32'h1, 1'b1};
        tbl[15] = '{32'h0, 32'h8, 32'h1, 32'h0, 32'h0, 32'h0, 32'h1, 1'b0};
        tbl[16] = '{32'h0, 32'h8, 32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 1'b0};

        @(negedge sys_clk);
        #1;
        check("reset_filt", gpio_filtered, '0);
        check("reset_pend", irq_pending, '0);
        check("reset_irq", {31'd0, irq_out}, 32'd0);
        apply_reset();

        for (int i = 0; i < 17; i++) begin
            gpio_input  = tbl[i].raw;
            irq_rise_en = tbl[i].rise;
            irq_fall_en = tbl[i].fall;
            irq_mask    = tbl[i].mask;
            irq_clr     = tbl[i].clr;
            tick();
            check($sformatf("tbl%0d_filt", i), gpio_filtered, tbl[i].efilt);
            check($sformatf("tbl%0d_pend", i), irq_pending, tbl[i].epend);
            check($sformatf("tbl%0d_irq", i), {31'd0, irq_out}, {31'd0, tbl[i].eirq});
        end

        // Debounce: a 6-cycle glitch is rejected, a long pulse lands on edge 13.
        apply_reset();
        db_en = 32'h20; db_limit = 8'd10; irq_rise_en = 32'h20; irq_mask = 32'h20;
        seen = '0;
        gpio_input = 32'h20;
        repeat (6) begin tick(); seen |= gpio_filtered | irq_pending; end
        gpio_input = '0;
        repeat (20) begin tick(); seen |= gpio_filtered | irq_pending; end
        check("glitch_rejected", seen, '0);
        gpio_input = 32'h20;
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 12) check("db_edge12_filt", gpio_filtered, '0);
            if (e == 13) begin
                check("db_edge13_filt", gpio_filtered, 32'h20);
                check("db_edge13_pend", irq_pending, 32'h20);
            end
        end
        tick();
        check("db_irq", {31'd0, irq_out}, 32'd1);

        // W1C race: clear coincident with a new rise loses.
        apply_reset();
        irq_rise_en = 32'h80; irq_mask = 32'h80; gpio_input = 32'h80;
        tick(); tick();
        irq_clr = 32'h80;
        tick();
        check("race_pend", irq_pending, 32'h80);
        tick();
        check("clr_pend", irq_pending, '0);
        check("clr_irq_hold", {31'd0, irq_out}, 32'd1);
        irq_clr = '0;
        tick();
        check("clr_irq_drop", {31'd0, irq_out}, 32'd0);

        // Reset in the middle of a debounce count with every pin pending.
        apply_reset();
        irq_rise_en = '1; irq_mask = '1; gpio_input = '1;
        repeat (3) tick();
        check("allpend", irq_pending, '1);
        db_en = '1; db_limit = 8'd10; gpio_input = 32'h0000_FFFF;
        repeat (4) tick();
        #2 sys_rst_n = 1'b0;
        #1;
        check("midrst_filt", gpio_filtered, '0);
        check("midrst_pend", irq_pending, '0);
        check("midrst_irq", {31'd0, irq_out}, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
        db_en = '0;
        repeat (2) tick();
        check("postrst_quiet", irq_pending, '0);
        tick();
        check("postrst_filt", gpio_filtered, 32'h0000_FFFF);
        check("postrst_pend", irq_pending, 32'h0000_FFFF);

        // Randomized traffic against the model.
        apply_reset();
        db_en = $urandom; db_limit = W'($urandom_range(0, 4));
        irq_rise_en = $urandom; irq_fall_en = $urandom; irq_mask = $urandom;
`ifdef GPIO_IRQ_LEVEL_EN
        irq_level_sel = $urandom & $urandom;
`endif
        for (int c = 0; c < 600; c++) begin
            gpio_input = gpio_input ^ ($urandom & $urandom & $urandom);
            irq_clr = ($urandom_range(0, 3) == 0) ? $urandom : '0;
            if ($urandom_range(0, 15) == 0) irq_mask = $urandom;
            if ($urandom_range(0, 31) == 0) db_limit = W'($urandom_range(0, 4));
            if ($urandom_range(0, 63) == 0) db_en = $urandom;
            if ($urandom_range(0, 63) == 0) irq_rise_en = $urandom;
            tick();
            check($sformatf("rnd%0d_filt", c), gpio_filtered, m_filt);
            check($sformatf("rnd%0d_pend", c), irq_pending, m_pend);
            check($sformatf("rnd%0d_irq", c), {31'd0, irq_out}, {31'd0, m_irq});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
